// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding taps, redirect and EX/MEM register outputs of the execute stage.
// The master side drives ID/EX and pipeline control; the slave side is the execute stage.
interface ex_stage_if;
    logic        MEM_Pause;
    logic        MEM_Flush;
    logic [31:0] EX_pc4_i;
    logic        EX_Branch;
    logic        EX_Jump;
    logic        EX_Jalr;
    logic [1:0]  EX_ALUOp;
    logic        EX_ALUSrc;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic        EX_MemtoReg;
    logic        EX_RegWrite;
    logic [4:0]  EX_rs1_addr;
    logic [4:0]  EX_rs2_addr;
    logic [4:0]  EX_rd_addr;
    logic [31:0] EX_rs1_v;
    logic [31:0] EX_rs2_v;
    logic [31:0] EX_imm32;
    logic [2:0]  EX_funct3;
    logic [6:0]  EX_funct7;
    logic        fwd_mem_RegWrite;
    logic [4:0]  fwd_mem_rd;
    logic [31:0] fwd_mem_v;
    logic        fwd_wb_RegWrite;
    logic [4:0]  fwd_wb_rd;
    logic [31:0] fwd_wb_v;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ex_busy;
    logic [31:0] MEM_pc4_o;
    logic [31:0] MEM_alu_result;
    logic [31:0] MEM_rs2_v;
    logic [4:0]  MEM_rd_addr;
    logic [2:0]  MEM_funct3;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic        MEM_MemtoReg;
    logic        MEM_RegWrite;

    modport master (
        output MEM_Pause, MEM_Flush, EX_pc4_i, EX_Branch, EX_Jump, EX_Jalr, EX_ALUOp, EX_ALUSrc,
               EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_RegWrite, EX_rs1_addr, EX_rs2_addr,
               EX_rd_addr, EX_rs1_v, EX_rs2_v, EX_imm32, EX_funct3, EX_funct7,
               fwd_mem_RegWrite, fwd_mem_rd, fwd_mem_v, fwd_wb_RegWrite, fwd_wb_rd, fwd_wb_v,
        input  redirect_valid, redirect_pc, ex_busy, MEM_pc4_o, MEM_alu_result, MEM_rs2_v,
               MEM_rd_addr, MEM_funct3, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite
    );

    modport slave (
        input  MEM_Pause, MEM_Flush, EX_pc4_i, EX_Branch, EX_Jump, EX_Jalr, EX_ALUOp, EX_ALUSrc,
               EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_RegWrite, EX_rs1_addr, EX_rs2_addr,
               EX_rd_addr, EX_rs1_v, EX_rs2_v, EX_imm32, EX_funct3, EX_funct7,
               fwd_mem_RegWrite, fwd_mem_rd, fwd_mem_v, fwd_wb_RegWrite, fwd_wb_rd, fwd_wb_v,
        output redirect_valid, redirect_pc, ex_busy, MEM_pc4_o, MEM_alu_result, MEM_rs2_v,
               MEM_rd_addr, MEM_funct3, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch/jump redirect; EX/MEM register 1 cycle, held by MEM_Pause.
// Define RV32M_MUL_EN for the iterative shift-add MUL, which stalls the front end through ex_busy.
module ex_stage #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input logic       clk,
    input logic       rstn,
    ex_stage_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rs2;
        logic [4:0]      rd;
        logic [2:0]      f3;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            reg_write;
    } exmem_t;

    logic [XLEN-1:0] rs1f, rs2f, opb, alu;
    logic [4:0]      shamt;
    logic            taken, redir_raw;
    exmem_t          exmem_q, exmem_d, exmem_norm;

    // MEM stage result is younger than WB, so it wins; rd==0 never matches
    always_comb begin
        rs1f = bus.EX_rs1_v;
        if (bus.fwd_mem_RegWrite && bus.fwd_mem_rd != 5'd0 && bus.fwd_mem_rd == bus.EX_rs1_addr)
            rs1f = bus.fwd_mem_v;
        else if (bus.fwd_wb_RegWrite && bus.fwd_wb_rd != 5'd0 && bus.fwd_wb_rd == bus.EX_rs1_addr)
            rs1f = bus.fwd_wb_v;
        rs2f = bus.EX_rs2_v;
        if (bus.fwd_mem_RegWrite && bus.fwd_mem_rd != 5'd0 && bus.fwd_mem_rd == bus.EX_rs2_addr)
            rs2f = bus.fwd_mem_v;
        else if (bus.fwd_wb_RegWrite && bus.fwd_wb_rd != 5'd0 && bus.fwd_wb_rd == bus.EX_rs2_addr)
            rs2f = bus.fwd_wb_v;
    end

    assign opb   = bus.EX_ALUSrc ? bus.EX_imm32 : rs2f;
    assign shamt = opb[4:0];

`ifdef RV32M_MUL_EN
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;

    mul_state_t      mstate;
    logic [CNT_W-1:0] mcnt;
    logic [XLEN-1:0] mcand, mplier, mprod, mprod_step;
    logic [4:0]      mrd;
    logic            mrw, is_mul, mul_issue, mul_last;

    assign is_mul     = bus.EX_ALUOp == 2'b10 && bus.EX_funct7 == 7'b0000001;
    assign mul_issue  = mstate == MUL_IDLE && is_mul && bus.EX_funct3 == 3'b000 && !bus.MEM_Flush;
    assign mul_last   = mstate == MUL_RUN && mcnt == CNT_LAST;
    assign mprod_step = mprod + (mplier[0] ? mcand : '0);
    assign bus.ex_busy        = mul_issue || mstate != MUL_IDLE;
    assign bus.redirect_valid = redir_raw && mstate == MUL_IDLE;
`else
    assign bus.ex_busy        = 1'b0;
    assign bus.redirect_valid = redir_raw;
`endif

    always_comb begin
        alu = '0;
        case (bus.EX_ALUOp)
            2'b00: alu = rs1f + opb;
            2'b01: alu = rs1f - opb;
            default: begin
                case (bus.EX_funct3)
                    3'b000: alu = (bus.EX_ALUOp == 2'b10 && bus.EX_funct7[5]) ? rs1f - opb : rs1f + opb;
                    3'b001: alu = rs1f << shamt;
                    3'b010: alu = {{(XLEN-1){1'b0}}, $signed(rs1f) < $signed(opb)};
                    3'b011: alu = {{(XLEN-1){1'b0}}, rs1f < opb};
                    3'b100: alu = rs1f ^ opb;
                    3'b101: alu = bus.EX_funct7[5] ? XLEN'($signed(rs1f) >>> shamt) : rs1f >> shamt;
                    3'b110: alu = rs1f | opb;
                    default: alu = rs1f & opb;
                endcase
`ifdef RV32M_MUL_EN
                if (is_mul) alu = '0;
`endif
            end
        endcase
    end

    always_comb begin
        case (bus.EX_funct3)
            3'b000:  taken = rs1f == rs2f;
            3'b001:  taken = rs1f != rs2f;
            3'b100:  taken = $signed(rs1f) < $signed(rs2f);
            3'b101:  taken = $signed(rs1f) >= $signed(rs2f);
            3'b110:  taken = rs1f < rs2f;
            3'b111:  taken = rs1f >= rs2f;
            default: taken = 1'b0;
        endcase
    end

    assign redir_raw       = (bus.EX_Branch && bus.EX_ALUOp == 2'b01 && taken) || bus.EX_Jump || bus.EX_Jalr;
    assign bus.redirect_pc = bus.EX_Jalr ? ((rs1f + bus.EX_imm32) & ~32'd1)
                                         : (bus.EX_pc4_i - 32'd4) + bus.EX_imm32;

    always_comb begin
        exmem_norm.pc4        = bus.EX_pc4_i;
        exmem_norm.alu        = (bus.EX_Jump || bus.EX_Jalr) ? bus.EX_pc4_i : alu;
        exmem_norm.rs2        = rs2f;
        exmem_norm.rd         = bus.EX_rd_addr;
        exmem_norm.f3         = bus.EX_funct3;
        exmem_norm.mem_read   = bus.EX_MemRead;
        exmem_norm.mem_write  = bus.EX_MemWrite;
        exmem_norm.mem_to_reg = bus.EX_MemtoReg;
        exmem_norm.reg_write  = bus.EX_RegWrite;
    end

    // while a MUL is in flight, only bubbles or its own result enter EX/MEM
    always_comb begin
        exmem_d = '0;
`ifdef RV32M_MUL_EN
        if (mul_last || mstate == MUL_DONE) begin
            exmem_d.alu       = mul_last ? mprod_step : mprod;
            exmem_d.rd        = mrd;
            exmem_d.reg_write = mrw;
        end else if (mstate == MUL_IDLE && !mul_issue) begin
            exmem_d = exmem_norm;
        end
`else
        exmem_d = exmem_norm;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            exmem_q <= '0;
`ifdef RV32M_MUL_EN
            mstate <= MUL_IDLE;
            mcnt   <= '0;
            mcand  <= '0;
            mplier <= '0;
            mprod  <= '0;
            mrd    <= '0;
            mrw    <= 1'b0;
`endif
        end else begin
            if (bus.MEM_Flush)      exmem_q <= '0;
            else if (!bus.MEM_Pause) exmem_q <= exmem_d;
`ifdef RV32M_MUL_EN
            if (bus.MEM_Flush) begin
                mstate <= MUL_IDLE;
            end else begin
                case (mstate)
                    MUL_IDLE: if (mul_issue) begin
                        mstate <= MUL_RUN;
                        mcnt   <= '0;
                        mcand  <= rs1f;
                        mplier <= rs2f;
                        mprod  <= '0;
                        mrd    <= bus.EX_rd_addr;
                        mrw    <= bus.EX_RegWrite;
                    end
                    MUL_RUN: begin
                        mprod  <= mprod_step;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        mcnt   <= mcnt + 1'b1;
                        if (mul_last) mstate <= bus.MEM_Pause ? MUL_DONE : MUL_IDLE;
                    end
                    MUL_DONE: if (!bus.MEM_Pause) mstate <= MUL_IDLE;
                    default:  mstate <= MUL_IDLE;
                endcase
            end
`endif
        end
    end

    assign bus.MEM_pc4_o      = exmem_q.pc4;
    assign bus.MEM_alu_result = exmem_q.alu;
    assign bus.MEM_rs2_v      = exmem_q.rs2;
    assign bus.MEM_rd_addr    = exmem_q.rd;
    assign bus.MEM_funct3     = exmem_q.f3;
    assign bus.MEM_MemRead    = exmem_q.mem_read;
    assign bus.MEM_MemWrite   = exmem_q.mem_write;
    assign bus.MEM_MemtoReg   = exmem_q.mem_to_reg;
    assign bus.MEM_RegWrite   = exmem_q.reg_write;
endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage: behavioural reference model checked every cycle, plus literal scenarios.
module tb_ex_stage;
    localparam int MULC = 32;

    logic clk = 1'b0;
    logic rstn;
    logic chk_en = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ex_stage_if bus();
    ex_stage dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct {
        logic [31:0] pc4, alu, rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        mr, mw, m2r, rw, alu_known;
    } em_t;

    em_t         exp_em;
    bit          m_act = 1'b0;
    int          m_left = 0;
    logic [31:0] m_res;
    logic [4:0]  m_rd;
    logic        m_rw;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] v);
        if (a != 0 && bus.fwd_mem_RegWrite && bus.fwd_mem_rd == a) return bus.fwd_mem_v;
        if (a != 0 && bus.fwd_wb_RegWrite && bus.fwd_wb_rd == a) return bus.fwd_wb_v;
        return v;
    endfunction

    function automatic bit is_mul_now();
`ifdef RV32M_MUL_EN
        return bus.EX_ALUOp == 2'd2 && bus.EX_funct7 == 7'd1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] alu_ref();
        logic [31:0] a, b;
        int sh;
        a  = fwd(bus.EX_rs1_addr, bus.EX_rs1_v);
        b  = bus.EX_ALUSrc ? bus.EX_imm32 : fwd(bus.EX_rs2_addr, bus.EX_rs2_v);
        sh = int'(b % 32);
        if (bus.EX_ALUOp == 2'd0) return a + b;
        if (bus.EX_ALUOp == 2'd1) return 32'd0;
        if (is_mul_now()) return 32'd0;
        case (bus.EX_funct3)
            3'd0: return (bus.EX_ALUOp == 2'd2 && bus.EX_funct7[5]) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return bus.EX_funct7[5] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic bit redirect_ref(output logic [31:0] pc);
        logic [31:0] a, b;
        bit t;
        a = fwd(bus.EX_rs1_addr, bus.EX_rs1_v);
        b = fwd(bus.EX_rs2_addr, bus.EX_rs2_v);
        case (bus.EX_funct3)
            3'd0: t = a == b;
            3'd1: t = a != b;
            3'd4: t = $signed(a) < $signed(b);
            3'd5: t = $signed(a) >= $signed(b);
            3'd6: t = a < b;
            3'd7: t = a >= b;
            default: t = 1'b0;
        endcase
        pc = bus.EX_Jalr ? ((a + bus.EX_imm32) & 32'hFFFF_FFFE) : bus.EX_pc4_i - 4 + bus.EX_imm32;
        return (bus.EX_Branch && bus.EX_ALUOp == 2'd1 && t) || bus.EX_Jump || bus.EX_Jalr;
    endfunction

    function automatic bit issue_ref();
        return !m_act && is_mul_now() && bus.EX_funct3 == 3'd0 && !bus.MEM_Flush;
    endfunction

    function automatic em_t zero_em();
        em_t z;
        z = '{pc4: 0, alu: 0, rs2: 0, rd: 0, f3: 0, mr: 0, mw: 0, m2r: 0, rw: 0, alu_known: 1};
        return z;
    endfunction

    // reference model: next EX/MEM contents from the inputs present at the edge
    always @(posedge clk) begin
        em_t nrm;
        bit  iss;
        nrm.pc4 = bus.EX_pc4_i;
        nrm.alu = (bus.EX_Jump || bus.EX_Jalr) ? bus.EX_pc4_i : alu_ref();
        nrm.alu_known = !(bus.EX_ALUOp == 2'd1 && !bus.EX_Jump && !bus.EX_Jalr);
        nrm.rs2 = fwd(bus.EX_rs2_addr, bus.EX_rs2_v);
        nrm.rd  = bus.EX_rd_addr;
        nrm.f3  = bus.EX_funct3;
        nrm.mr  = bus.EX_MemRead;
        nrm.mw  = bus.EX_MemWrite;
        nrm.m2r = bus.EX_MemtoReg;
        nrm.rw  = bus.EX_RegWrite;
        iss = issue_ref();
        if (!rstn) begin
            exp_em = zero_em();
            m_act  = 1'b0;
        end else if (bus.MEM_Flush) begin
            exp_em = zero_em();
            m_act  = 1'b0;
        end else if (m_act) begin
            if (m_left > 0) m_left--;
            if (m_left == 0) begin
                if (!bus.MEM_Pause) begin
                    exp_em     = zero_em();
                    exp_em.alu = m_res;
                    exp_em.rd  = m_rd;
                    exp_em.rw  = m_rw;
                    m_act      = 1'b0;
                end
            end else if (!bus.MEM_Pause) begin
                exp_em = zero_em();
            end
        end else if (iss) begin
            m_act  = 1'b1;
            m_left = MULC;
            m_res  = fwd(bus.EX_rs1_addr, bus.EX_rs1_v) * fwd(bus.EX_rs2_addr, bus.EX_rs2_v);
            m_rd   = bus.EX_rd_addr;
            m_rw   = bus.EX_RegWrite;
            if (!bus.MEM_Pause) exp_em = zero_em();
        end else if (!bus.MEM_Pause) begin
            exp_em = nrm;
        end
    end

    always @(negedge clk) begin
        logic [31:0] rpc;
        bit rv;
        if (chk_en) begin
            rv = redirect_ref(rpc) && !m_act;
            cmp("redirect_valid", 32'(bus.redirect_valid), 32'(rv));
            if (rv) cmp("redirect_pc", bus.redirect_pc, rpc);
            cmp("ex_busy", 32'(bus.ex_busy), 32'(m_act || issue_ref()));
            cmp("MEM_pc4_o", bus.MEM_pc4_o, exp_em.pc4);
            if (exp_em.alu_known) cmp("MEM_alu_result", bus.MEM_alu_result, exp_em.alu);
            cmp("MEM_rs2_v", bus.MEM_rs2_v, exp_em.rs2);
            cmp("MEM_rd_addr", 32'(bus.MEM_rd_addr), 32'(exp_em.rd));
            cmp("MEM_funct3", 32'(bus.MEM_funct3), 32'(exp_em.f3));
            cmp("MEM_ctrl", {28'd0, bus.MEM_MemRead, bus.MEM_MemWrite, bus.MEM_MemtoReg, bus.MEM_RegWrite},
                {28'd0, exp_em.mr, exp_em.mw, exp_em.m2r, exp_em.rw});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        bus.MEM_Pause = 0; bus.MEM_Flush = 0; bus.EX_pc4_i = 0;
        bus.EX_Branch = 0; bus.EX_Jump = 0; bus.EX_Jalr = 0; bus.EX_ALUOp = 0; bus.EX_ALUSrc = 0;
        bus.EX_MemRead = 0; bus.EX_MemWrite = 0; bus.EX_MemtoReg = 0; bus.EX_RegWrite = 0;
        bus.EX_rs1_addr = 0; bus.EX_rs2_addr = 0; bus.EX_rd_addr = 0;
        bus.EX_rs1_v = 0; bus.EX_rs2_v = 0; bus.EX_imm32 = 0; bus.EX_funct3 = 0; bus.EX_funct7 = 0;
        bus.fwd_mem_RegWrite = 0; bus.fwd_mem_rd = 0; bus.fwd_mem_v = 0;
        bus.fwd_wb_RegWrite = 0; bus.fwd_wb_rd = 0; bus.fwd_wb_v = 0;
    endtask

    task automatic rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        bubble();
        bus.EX_ALUOp = 2'd2; bus.EX_funct7 = f7; bus.EX_funct3 = f3;
        bus.EX_rs1_addr = 5'd1; bus.EX_rs2_addr = 5'd2; bus.EX_rs1_v = a; bus.EX_rs2_v = b;
        bus.EX_rd_addr = rd; bus.EX_RegWrite = 1;
    endtask

    task automatic randomize_inputs();
        int c;
        bubble();
        bus.MEM_Pause = ($urandom_range(0, 6) == 0);
        bus.MEM_Flush = ($urandom_range(0, 15) == 0);
        bus.EX_pc4_i  = $urandom;
        bus.EX_rs1_addr = 5'($urandom_range(0, 7));
        bus.EX_rs2_addr = 5'($urandom_range(0, 7));
        bus.EX_rd_addr  = 5'($urandom_range(0, 31));
        bus.EX_rs1_v = $urandom;
        bus.EX_rs2_v = ($urandom_range(0, 3) == 0) ? bus.EX_rs1_v : $urandom;
        bus.EX_imm32 = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
        bus.EX_funct3 = 3'($urandom);
        case ($urandom_range(0, 2))
            0: bus.EX_funct7 = 7'h00;
            1: bus.EX_funct7 = 7'h20;
            default: bus.EX_funct7 = 7'h01;
        endcase
        bus.fwd_mem_RegWrite = 1'($urandom); bus.fwd_mem_rd = 5'($urandom_range(0, 7)); bus.fwd_mem_v = $urandom;
        bus.fwd_wb_RegWrite = 1'($urandom);  bus.fwd_wb_rd = 5'($urandom_range(0, 7));  bus.fwd_wb_v = $urandom;
        c = $urandom_range(0, 6);
        case (c)
            0: begin bus.EX_ALUOp = 2'd2; bus.EX_RegWrite = 1; end
            1: begin bus.EX_ALUOp = 2'd3; bus.EX_ALUSrc = 1; bus.EX_RegWrite = 1; end
            2: begin
                bus.EX_ALUSrc = 1;
                if ($urandom_range(0, 1) == 0) begin bus.EX_MemRead = 1; bus.EX_MemtoReg = 1; bus.EX_RegWrite = 1; end
                else bus.EX_MemWrite = 1;
            end
            3: begin bus.EX_ALUOp = 2'd1; bus.EX_Branch = 1; end
            4: begin bus.EX_Jump = 1; bus.EX_RegWrite = 1; end
            5: begin bus.EX_Jalr = 1; bus.EX_ALUSrc = 1; bus.EX_RegWrite = 1; end
            default: ;
        endcase
    endtask

    initial begin
        int busy_n;
        bubble();
        rstn = 0;
        tick();
        chk_en = 1;
        tick();
        cmp("reset alu", bus.MEM_alu_result, 32'd0);
        cmp("reset busy", 32'(bus.ex_busy), 32'd0);
        rstn = 1;

        rtype(7'h00, 3'd0, 32'd5, 32'd7, 5'd3);
        tick();
        cmp("add result", bus.MEM_alu_result, 32'd12);
        cmp("add rd", 32'(bus.MEM_rd_addr), 32'd3);
        cmp("add regwrite", 32'(bus.MEM_RegWrite), 32'd1);

        bubble();
        bus.EX_ALUOp = 2'd3; bus.EX_ALUSrc = 1; bus.EX_imm32 = 32'd1; bus.EX_rs1_addr = 5'd4;
        bus.EX_rd_addr = 5'd6; bus.EX_RegWrite = 1;
        bus.fwd_mem_RegWrite = 1; bus.fwd_mem_rd = 5'd4; bus.fwd_mem_v = 32'd100;
        bus.fwd_wb_RegWrite = 1;  bus.fwd_wb_rd = 5'd4;  bus.fwd_wb_v = 32'd200;
        tick();
        cmp("fwd priority", bus.MEM_alu_result, 32'd101);

        bubble();
        bus.EX_ALUOp = 2'd1; bus.EX_Branch = 1; bus.EX_funct3 = 3'd4; bus.EX_pc4_i = 32'h104;
        bus.EX_imm32 = 32'h20; bus.EX_rs1_addr = 5'd1; bus.EX_rs2_addr = 5'd2;
        bus.EX_rs1_v = 32'hFFFF_FFFF; bus.EX_rs2_v = 32'd1;
        #1;
        cmp("blt valid", 32'(bus.redirect_valid), 32'd1);
        cmp("blt target", bus.redirect_pc, 32'h120);
        bus.EX_funct3 = 3'd6;
        #1;
        cmp("bltu valid", 32'(bus.redirect_valid), 32'd0);
        tick();

        bubble();
        bus.EX_Jalr = 1; bus.EX_ALUSrc = 1; bus.EX_rs1_addr = 5'd1; bus.EX_rs1_v = 32'h1001;
        bus.EX_imm32 = 32'd4; bus.EX_pc4_i = 32'h208; bus.EX_rd_addr = 5'd1; bus.EX_RegWrite = 1;
        #1;
        cmp("jalr target", bus.redirect_pc, 32'h1004);
        tick();
        cmp("jalr link", bus.MEM_alu_result, 32'h208);

        rtype(7'h00, 3'd0, 32'd5, 32'd7, 5'd3);
        bus.MEM_Pause = 1;
        tick();
        cmp("pause hold", bus.MEM_alu_result, 32'h208);
        bus.MEM_Pause = 0; bus.MEM_Flush = 1;
        tick();
        cmp("flush alu", bus.MEM_alu_result, 32'd0);
        cmp("flush pc4", bus.MEM_pc4_o, 32'd0);
        bus.MEM_Flush = 0;
        tick();
        cmp("sub-reset load", bus.MEM_alu_result, 32'd12);
        rstn = 0;
        tick();
        cmp("rst alu", bus.MEM_alu_result, 32'd0);
        cmp("rst regwrite", 32'(bus.MEM_RegWrite), 32'd0);
        rstn = 1;

`ifdef RV32M_MUL_EN
        rtype(7'h01, 3'd0, 32'h0000_FFFF, 32'h0001_0001, 5'd5);
        #1;
        busy_n = bus.ex_busy ? 1 : 0;
        tick();
        bubble();
        for (int k = 0; k < 100; k++) begin
            if (!bus.ex_busy) break;
            busy_n++;
            tick();
        end
        cmp("mul busy cycles", 32'(busy_n), 32'd33);
        cmp("mul product", bus.MEM_alu_result, 32'hFFFF_FFFF);
        cmp("mul rd", 32'(bus.MEM_rd_addr), 32'd5);
        rtype(7'h01, 3'd0, 32'd3, 32'd4, 5'd7);
        tick();
        bubble();
        repeat (4) tick();
        rstn = 0;
        tick();
        cmp("mul rst busy", 32'(bus.ex_busy), 32'd0);
        rstn = 1;
        tick();
        cmp("mul idle after rst", 32'(bus.ex_busy), 32'd0);
`else
        busy_n = 0;
        rtype(7'h01, 3'd0, 32'd6, 32'd9, 5'd5);
        #1;
        cmp("no-mul busy", 32'(bus.ex_busy), 32'(busy_n));
        tick();
        cmp("no-mul as add", bus.MEM_alu_result, 32'd15);
`endif

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            rstn = ($urandom_range(0, 99) != 0);
            tick();
        end
        bubble();
        rstn = 1;
        repeat (3) tick();
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
